// File: rtl/lc3b_types.sv
// Shared line-level types for the 128-bit line responder and its storage.
package lc3b_types;

  localparam int unsigned LINE_BYTES = 16;

  typedef logic [8*LINE_BYTES-1:0] lc3b_line;
  typedef logic [LINE_BYTES-1:0]   lc3b_line_sel;

endpackage

// File: rtl/wb_line_responder_if.sv
// Wishbone classic-cycle bus carrying one 128-bit line per transfer.
interface wb_line_responder_if
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 12
);

  logic              CYC;
  logic              STB;
  logic              WE;
  logic [ADDR_W-1:0] ADR;
  lc3b_line_sel      SEL;
  lc3b_line          DAT_M;
  lc3b_line          DAT_S;
  logic              ACK;
  logic              ERR;

  modport master (
    output CYC, STB, WE, ADR, SEL, DAT_M,
    input  DAT_S, ACK, ERR
  );

  modport slave (
    input  CYC, STB, WE, ADR, SEL, DAT_M,
    output DAT_S, ACK, ERR
  );

endinterface

// File: rtl/wb_line_array.sv
// DEPTH x 128-bit line storage: byte-lane synchronous write, combinational read.
module wb_line_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  lc3b_line_sel     sel,
  input  lc3b_line         wdata,
  output lc3b_line         rdata
);

  lc3b_line mem [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (sel[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/wb_line_responder.sv
// Wishbone classic slave answering 128-bit line reads/writes from an internal
// line array, with configurable wait states, CYC-drop abort and range errors.
module wb_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  wb_line_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  lc3b_line_sel     sel_q, sel_d;
  lc3b_line         dat_q, dat_d;
  logic             oor_q, oor_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic     adr_oor;
  logic     wr_en;
  lc3b_line rdata;

  assign adr_oor = 32'(bus.ADR) >= DEPTH;

  // WAIT always lasts WAIT_CYCLES+1 cycles (the counter runs down to zero), so
  // ACK/ERR lands WAIT_CYCLES+1 edges after the capturing edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    oor_d   = oor_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.CYC && bus.STB) begin
          idx_d   = bus.ADR[IDX_W-1:0];
          we_d    = bus.WE;
          sel_d   = bus.SEL;
          dat_d   = bus.DAT_M;
          oor_d   = adr_oor;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (!bus.CYC) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StResp;
          ack_d   = !oor_q;
          err_d   = oor_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // The write commits on the edge that ends RESP; reset before then drops it.
  assign wr_en = (state_q == StResp) && we_q && !oor_q;

  wb_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .idx   (idx_q),
    .sel   (sel_q),
    .wdata (dat_q),
    .rdata (rdata)
  );

  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.DAT_S = ((state_q == StResp) && !oor_q && !we_q) ? rdata : '0;

endmodule

// File: tb/tb_wb_line_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder driven by
// a vector table, hand-written corner sequences and a random run against a model.
module tb_wb_line_responder;
  import lc3b_types::*;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0, use0 = 1'b0;
  logic [11:0]  adr = '0;
  lc3b_line_sel sel = '0;
  lc3b_line     datm = '0;

  wb_line_responder_if #(.ADDR_W(12)) bus2 ();
  wb_line_responder_if #(.ADDR_W(12)) bus0 ();

  assign bus2.CYC = cyc & ~use0;
  assign bus2.STB = stb & ~use0;
  assign bus2.WE = we;
  assign bus2.ADR = adr;
  assign bus2.SEL = sel;
  assign bus2.DAT_M = datm;
  assign bus0.CYC = cyc & use0;
  assign bus0.STB = stb & use0;
  assign bus0.WE = we;
  assign bus0.ADR = adr;
  assign bus0.SEL = sel;
  assign bus0.DAT_M = datm;

  logic     ack, err;
  lc3b_line dats;
  assign ack  = use0 ? bus0.ACK : bus2.ACK;
  assign err  = use0 ? bus0.ERR : bus2.ERR;
  assign dats = use0 ? bus0.DAT_S : bus2.DAT_S;

  wb_line_responder #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  wb_line_responder #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int total = 0;
  int bad = 0;

  // Reference memory: only lines whose full contents are known; key = dut*4096 + line.
  lc3b_line model [int];

  typedef struct {
    logic         w;
    logic [11:0]  a;
    lc3b_line_sel s;
    lc3b_line     d;
    logic         e_ack;
    logic         e_err;
    lc3b_line     e_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input lc3b_line got, input lc3b_line exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_write(input logic [11:0] a, input lc3b_line_sel s, input lc3b_line d);
    int key;
    lc3b_line line;
    key = (use0 ? 4096 : 0) + int'(a);
    if (int'(a) >= DEPTH) return;
    if (model.exists(key)) begin
      line = model[key];
      for (int i = 0; i < LINE_BYTES; i++) if (s[i]) line[8*i +: 8] = d[8*i +: 8];
      model[key] = line;
    end else if (s == 16'hFFFF) begin
      model[key] = d;
    end
  endtask

  // One complete request; checks latency, response kind, data and single-cycle pulse.
  task automatic txn(input string nm, input logic w, input logic [11:0] a,
                     input lc3b_line_sel s, input lc3b_line d, input logic e_ack,
                     input logic e_err, input lc3b_line e_dat, input bit chk_dat);
    int lat;
    int exp_lat;
    bit seen;
    exp_lat = use0 ? 1 : 3;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; datm = d;
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (ack || err) seen = 1'b1;
    end
    chk({nm, ".lat"}, 128'(lat), 128'(exp_lat));
    chk({nm, ".ack"}, 128'(ack), 128'(e_ack));
    chk({nm, ".err"}, 128'(err), 128'(e_err));
    if (chk_dat) chk({nm, ".dat"}, dats, e_dat);
    cyc = 1'b0; stb = 1'b0;
    if (w) model_write(a, s, d);
    @(posedge clk);
    #1;
    chk({nm, ".pulse"}, 128'({ack, err}), 128'(0));
  endtask

  initial begin
    lc3b_line d1, aa, merged, d3, pat11, la, lb, l1, l2, e_dat;
    bit chk_dat;
    logic w;
    logic [11:0] a;
    lc3b_line_sel s;
    lc3b_line d;
    int key;
    bit oor;

    d1     = 128'h00112233445566778899AABBCCDDEEFF;
    aa     = {16{8'hAA}};
    merged = {{14{8'hAA}}, 16'h5555};
    d3     = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    pat11  = {16{8'h11}};

    vecs.push_back('{1'b1, 12'h005, 16'hFFFF, d1,    1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b0, 12'h005, 16'h0000, '0,    1'b1, 1'b0, d1});
    vecs.push_back('{1'b1, 12'h010, 16'hFFFF, aa,    1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b1, 12'h010, 16'h0003, 128'h5555, 1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b0, 12'h010, 16'hFFFF, '0,    1'b1, 1'b0, merged});
    vecs.push_back('{1'b0, 12'h100, 16'hFFFF, '0,    1'b0, 1'b1, 128'h0});
    vecs.push_back('{1'b0, 12'h010, 16'h0000, '0,    1'b1, 1'b0, merged});
    vecs.push_back('{1'b1, 12'h0FF, 16'hFFFF, d3,    1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b0, 12'h0FF, 16'h0000, '0,    1'b1, 1'b0, d3});
    vecs.push_back('{1'b1, 12'h030, 16'hFFFF, pat11, 1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b1, 12'h030, 16'h0000, ~pat11, 1'b1, 1'b0, 128'h0});
    vecs.push_back('{1'b0, 12'h030, 16'h0000, '0,    1'b1, 1'b0, pat11});
    vecs.push_back('{1'b1, 12'hFFF, 16'hFFFF, d1,    1'b0, 1'b1, 128'h0});
    vecs.push_back('{1'b0, 12'h0FF, 16'h0000, '0,    1'b1, 1'b0, d3});

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst2.ack", 128'(bus2.ACK), 128'(0));
    chk("rst2.err", 128'(bus2.ERR), 128'(0));
    chk("rst2.dat", bus2.DAT_S, 128'h0);
    chk("rst0.ack", 128'(bus0.ACK), 128'(0));
    chk("rst0.err", 128'(bus0.ERR), 128'(0));
    chk("rst0.dat", bus0.DAT_S, 128'h0);
    rst_n = 1'b1;

    use0 = 1'b0;
    foreach (vecs[i]) begin
      txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d,
          vecs[i].e_ack, vecs[i].e_err, vecs[i].e_dat, 1'b1);
    end

    // Abort: CYC dropped in the first WAIT cycle cancels the write.
    la = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    txn("abort.pre", 1'b1, 12'h020, 16'hFFFF, la, 1'b1, 1'b0, 128'h0, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h020; sel = 16'hFFFF; datm = 128'h1234;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort.quiet%0d", i), 128'({ack, err}), 128'(0));
    end
    txn("abort.rd", 1'b0, 12'h020, 16'h0000, '0, 1'b1, 1'b0, la, 1'b1);

    // Back-to-back reads on the zero-wait instance with STB held.
    use0 = 1'b1;
    l1 = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
    l2 = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
    txn("b2b.pre1", 1'b1, 12'h001, 16'hFFFF, l1, 1'b1, 1'b0, 128'h0, 1'b1);
    txn("b2b.pre2", 1'b1, 12'h002, 16'hFFFF, l2, 1'b1, 1'b0, 128'h0, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h001;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b.ack1", 128'(ack), 128'(1));
    chk("b2b.dat1", dats, l1);
    adr = 12'h002;
    @(posedge clk);
    #1;
    chk("b2b.idle", 128'({ack, err}), 128'(0));
    @(posedge clk);
    #1;
    chk("b2b.wait", 128'({ack, err}), 128'(0));
    @(posedge clk);
    #1;
    chk("b2b.ack2", 128'(ack), 128'(1));
    chk("b2b.dat2", dats, l2);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b.end", 128'({ack, err}), 128'(0));

    // Reset during WAIT of a write drops it; the responder then serves normally.
    use0 = 1'b0;
    lb = 128'hBBBB_BBBB_0000_0000_CCCC_CCCC_1111_1111;
    txn("rst.pre", 1'b1, 12'h040, 16'hFFFF, lb, 1'b1, 1'b0, 128'h0, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h040; sel = 16'hFFFF; datm = ~lb;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.mid", 128'({ack, err}), 128'(0));
    chk("rst.dat", dats, 128'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn("rst.rd", 1'b0, 12'h040, 16'h0000, '0, 1'b1, 1'b0, lb, 1'b1);

    // Random traffic on both instances against the reference memory.
    for (int n = 0; n < 60; n++) begin
      use0 = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 3:    a = 12'($urandom_range(0, 15));
        1:       a = 12'($urandom_range(248, 263));
        default: a = 12'($urandom_range(0, 4095));
      endcase
      s = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      oor = int'(a) >= DEPTH;
      key = (use0 ? 4096 : 0) + int'(a);
      chk_dat = 1'b1;
      e_dat = '0;
      if (!oor && !w) begin
        chk_dat = model.exists(key);
        if (chk_dat) e_dat = model[key];
      end
      txn($sformatf("rnd%0d", n), w, a, s, d, !oor, oor, e_dat, chk_dat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
